dpi_flow_ctx_sched: RTL and testbench
=====================================

Name: dpi_flow_ctx_sched

Overview:
Upstream feeder for the per-regex DFA matcher stages. Accepts a byte stream of interleaved packets tagged with a flow ID and keeps a per-flow DFA state context table. At each packet start it loads the flow's saved state into the matcher, then streams payload bytes into it. At packet end it writes the matcher's final state back to the table. Every matcher accept is queued as a {flow, byte offset} match report.

Parameters:
FLOW_W, 4, flow ID width; NUM_FLOWS = 2**FLOW_W contexts
STATE_W, 11, matcher state width
OFFS_W, 16, byte-offset counter width
FIFO_DEPTH, 8, match-report FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream byte valid
in_ready  out  1  byte accepted when in_valid&in_ready
in_data  in  8  payload byte
in_flow  in  FLOW_W  flow ID; sampled on the first beat of a packet only
in_sop  in  1  first byte of packet
in_eop  in  1  last byte of packet
ctx_clr  in  1  pulse: reset one flow context to state 0
ctx_clr_id  in  FLOW_W  flow to clear
m_char  out  8  to matcher char_in
m_char_vld  out  1  to matcher char_in_vld
m_state_in  out  STATE_W  to matcher state_in
m_state_vld  out  1  to matcher state_in_vld
m_state_out  in  STATE_W  from matcher state_out (registered current state)
m_accept  in  1  from matcher accept_out (combinational with m_char_vld)
match_valid  out  1  report FIFO not empty
match_ready  in  1  pop report
match_flow  out  FLOW_W  head report flow ID
match_offs  out  OFFS_W  head report byte offset (0 = first byte of packet)
overflow  out  1  sticky; a report was dropped
sop_err  out  1  sticky; a packet's first beat had in_sop=0

Behaviour:
- Reset (rst_n=0 at posedge): all contexts = 0, FSM=IDLE, FIFO empty, overflow=0, sop_err=0, offset=0. Outputs during and after reset: in_ready=0, m_char_vld=0, m_state_vld=0, match_valid=0.
- FSM states: IDLE, LOAD, STREAM, SAVE.
- IDLE: in_ready=0. When in_valid=1, latch act_flow=in_flow. Set sop_err if in_sop=0 (the beat is still treated as SOP). Go to LOAD. The byte is not consumed.
- LOAD: m_state_vld=1, m_state_in=ctx[act_flow]; offset<=0; go to STREAM.
- STREAM: in_ready=1, m_char=in_data, m_char_vld=in_valid, m_state_vld=0.
  - On each accepted beat: if m_accept=1, push {act_flow, offset}. Then offset <= offset+1, saturating at all-ones.
  - Accepted beat with in_eop=1 goes to SAVE. An in_sop=1 beat within STREAM is treated as data (no restart).
- SAVE: in_ready=0. ctx[act_flow] <= m_state_out, which now reflects the last byte. Write 0 instead if clr_pend is set or ctx_clr targets act_flow this cycle. Clear clr_pend; go to IDLE.
- Per-packet overhead is 3 non-streaming cycles (IDLE, LOAD, SAVE). Throughput within a packet is 1 byte/cycle.
- ctx_clr:
  - Target is not the active flow, or FSM is IDLE: ctx[id] <= 0 on the next edge.
  - Target is act_flow during LOAD or STREAM: set clr_pend. The running packet continues from its loaded state and SAVE writes 0.
  - Clear in the same cycle as a LOAD of the same flow: LOAD presents the old value; clr_pend is set.
- Report FIFO:
  - Push when full with no pop in the same cycle: drop the report, set overflow.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop when empty: the report is written; match_valid rises the next cycle (no fall-through).
  - match_flow and match_offs are stable while match_valid=1 and match_ready=0.
- Reset mid-packet: FSM returns to IDLE, contexts are zeroed, and in-flight bytes are lost. Upstream must restart at SOP.

Test Plan:
Bench stub matcher: next_state = state+1 per byte; accept when the next state equals 3.
- Single packet flow 2, 5 bytes from clean reset -> LOAD m_state_in=0; one report {2,2}; ctx[2]=5 after SAVE; exactly 3 idle cycles of in_ready=0.
- Flow 2 pkt of 2 bytes, then flow 5 pkt of 1 byte, then flow 2 pkt of 1 byte -> flow 2's second packet loads 2; report {2,0}; ctx[5]=1; ctx[2]=3.
- 1-byte packet with in_sop=in_eop=1 -> LOAD, one STREAM beat, SAVE; no report; ctx[flow]=1. Repeat with in_sop=0 -> sop_err=1.
- ctx_clr of active flow 3 mid-STREAM -> remaining bytes use the running state; ctx[3]=0 after SAVE. ctx_clr of idle flow 7 -> ctx[7]=0 the next cycle.
- match_ready held 0; 9 packets each producing one accept (FIFO_DEPTH=8) -> 8 reports retained in order; overflow=1; then a simultaneous push and pop at full loses nothing.
- Assert rst_n mid-STREAM -> in_ready=0, m_char_vld=0, match_valid=0; a subsequent packet loads 0 for every flow.

Source files
------------

// File: rtl/dpi_flow_ctx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : dpi_flow_ctx_sched_if
// Description : Bundle of all non-clock/reset signals of dpi_flow_ctx_sched.
//               slave  = scheduler side, master = environment side
//               (byte source, DFA matcher and report consumer).
//   Byte stream : in_valid/in_ready/in_data/in_flow/in_sop/in_eop
//   Context clr : ctx_clr/ctx_clr_id
//   Matcher     : m_char/m_char_vld/m_state_in/m_state_vld/m_state_out/m_accept
//   Reports     : match_valid/match_ready/match_flow/match_offs
//   Status      : overflow/sop_err (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
interface dpi_flow_ctx_sched_if #(
    parameter int FLOW_W  = 4,
    parameter int STATE_W = 11,
    parameter int OFFS_W  = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [FLOW_W-1:0]  in_flow;
    logic               in_sop;
    logic               in_eop;
    logic               ctx_clr;
    logic [FLOW_W-1:0]  ctx_clr_id;
    logic [7:0]         m_char;
    logic               m_char_vld;
    logic [STATE_W-1:0] m_state_in;
    logic               m_state_vld;
    logic [STATE_W-1:0] m_state_out;
    logic               m_accept;
    logic               match_valid;
    logic               match_ready;
    logic [FLOW_W-1:0]  match_flow;
    logic [OFFS_W-1:0]  match_offs;
    logic               overflow;
    logic               sop_err;

    modport slave (
        input  in_valid, in_data, in_flow, in_sop, in_eop,
        input  ctx_clr, ctx_clr_id,
        input  m_state_out, m_accept,
        input  match_ready,
        output in_ready, m_char, m_char_vld, m_state_in, m_state_vld,
        output match_valid, match_flow, match_offs, overflow, sop_err
    );

    modport master (
        output in_valid, in_data, in_flow, in_sop, in_eop,
        output ctx_clr, ctx_clr_id,
        output m_state_out, m_accept,
        output match_ready,
        input  in_ready, m_char, m_char_vld, m_state_in, m_state_vld,
        input  match_valid, match_flow, match_offs, overflow, sop_err
    );
endinterface
`default_nettype wire

// File: rtl/dpi_flow_ctx_sched.sv
`default_nettype none
// ============================================================================
// Module      : dpi_flow_ctx_sched
// Description : Per-flow DFA context scheduler. Loads a flow's saved matcher
//               state at packet start, streams payload bytes to the matcher
//               at 1 byte/cycle, writes the final state back at packet end
//               and queues every matcher accept as a {flow, offset} report.
// Ports       : clk, rst_n (synchronous, active-low)
//               bus (slave modport of dpi_flow_ctx_sched_if)
// Revision    : 1.0 - initial release
// ============================================================================
module dpi_flow_ctx_sched #(
    parameter int FLOW_W     = 4,
    parameter int STATE_W    = 11,
    parameter int OFFS_W     = 16,
    parameter int FIFO_DEPTH = 8     // power of 2, >= 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    dpi_flow_ctx_sched_if.slave  bus
);
    localparam int NUM_FLOWS = 1 << FLOW_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int REP_W     = FLOW_W + OFFS_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_SAVE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [FLOW_W-1:0]   act_flow_q;
    logic                clr_pend_q;
    logic [OFFS_W-1:0]   offs_q;
    logic                sop_err_q;
    logic                overflow_q;
    logic [STATE_W-1:0]  ctx_q [NUM_FLOWS];
    logic [REP_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      cnt_q, cnt_d;

    logic                w_beat;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_push_ok;
    logic                w_clr_hits_act;
    logic                w_save_zero;

    assign w_beat    = bus.in_valid && (state_q == S_STREAM);
    assign w_push    = w_beat && bus.m_accept;
    assign w_pop     = bus.match_ready && (cnt_q != '0);
    assign w_full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = w_push && (!w_full || w_pop);

    // A clear aimed at the flow that is loaded or streaming must not disturb
    // the running packet; it is deferred to the write-back in SAVE.
    assign w_clr_hits_act = bus.ctx_clr && (bus.ctx_clr_id == act_flow_q) &&
                            ((state_q == S_LOAD) || (state_q == S_STREAM));
    assign w_save_zero    = clr_pend_q ||
                            (bus.ctx_clr && (bus.ctx_clr_id == act_flow_q));

    assign bus.in_ready    = (state_q == S_STREAM);
    assign bus.m_char      = bus.in_data;
    assign bus.m_char_vld  = w_beat;
    assign bus.m_state_in  = ctx_q[act_flow_q];
    assign bus.m_state_vld = (state_q == S_LOAD);
    assign bus.match_valid = (cnt_q != '0);
    assign {bus.match_flow, bus.match_offs} = fifo_q[rd_ptr_q];
    assign bus.overflow    = overflow_q;
    assign bus.sop_err     = sop_err_q;

    // Packet sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            act_flow_q <= '0;
            clr_pend_q <= 1'b0;
            offs_q     <= '0;
            sop_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        act_flow_q <= bus.in_flow;
                        if (!bus.in_sop) begin
                            sop_err_q <= 1'b1;
                        end
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    offs_q  <= '0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_beat) begin
                        if (offs_q != {OFFS_W{1'b1}}) begin
                            offs_q <= offs_q + OFFS_W'(1);
                        end
                        if (bus.in_eop) begin
                            state_q <= S_SAVE;
                        end
                    end
                end
                default: begin
                    clr_pend_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
            if (w_clr_hits_act) begin
                clr_pend_q <= 1'b1;
            end
        end
    end

    // Context table: immediate clears plus the end-of-packet write-back.
    // Both may fire in one cycle only for different indices (or both zero).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            if (bus.ctx_clr && !w_clr_hits_act) begin
                ctx_q[bus.ctx_clr_id] <= '0;
            end
            if (state_q == S_SAVE) begin
                ctx_q[act_flow_q] <= w_save_zero ? '0 : bus.m_state_out;
            end
        end
    end

    // Match-report FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        cnt_d    = cnt_q + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (w_push && !w_push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            fifo_q[wr_ptr_q] <= {act_flow_q, offs_q};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dpi_flow_ctx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpi_flow_ctx_sched
// Description : Self-checking bench for dpi_flow_ctx_sched with a stub
//               matcher (state+1 per byte, accept when next state == 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpi_flow_ctx_sched;
    localparam int FLOW_W     = 4;
    localparam int STATE_W    = 11;
    localparam int OFFS_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int NUM_FLOWS  = 1 << FLOW_W;
    localparam int STATE_MOD  = 1 << STATE_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpi_flow_ctx_sched_if #(.FLOW_W(FLOW_W), .STATE_W(STATE_W), .OFFS_W(OFFS_W)) bus ();

    dpi_flow_ctx_sched #(
        .FLOW_W(FLOW_W), .STATE_W(STATE_W), .OFFS_W(OFFS_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub matcher
    logic [STATE_W-1:0] mst;
    always_ff @(posedge clk) begin
        if (!rst_n)               mst <= '0;
        else if (bus.m_state_vld) mst <= bus.m_state_in;
        else if (bus.m_char_vld)  mst <= mst + STATE_W'(1);
    end
    assign bus.m_state_out = mst;
    assign bus.m_accept    = bus.m_char_vld && ((mst + STATE_W'(1)) == STATE_W'(3));

    // Reference model: plain per-flow state values and a report queue
    typedef struct { int flow; int offs; } rep_t;
    int unsigned mctx [NUM_FLOWS];
    rep_t        q [$];
    bit          movf;
    bit          msop_err;

    int checks = 0;
    int errors = 0;

    int                 load_cnt = 0;
    logic [STATE_W-1:0] load_seen;
    always @(negedge clk) begin
        if (rst_n && bus.m_state_vld) begin
            load_cnt++;
            load_seen = bus.m_state_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FLOWS; i++) mctx[i] = 0;
        q.delete();
        movf = 1'b0;
        msop_err = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_flow = '0;
        bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.ctx_clr = 1'b0; bus.ctx_clr_id = '0; bus.match_ready = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Sends one packet; clr_at/pop_at (>=1, -1 = none) pulse ctx_clr /
    // match_ready together with that beat. Model is advanced per beat.
    task automatic send_pkt(input int f, input int len, input bit sop, input int clr_at,
                            input int clr_id, input int pop_at, output int stalls);
        int lc0;
        int unsigned load;
        bit pend;
        bit rdy;
        bit to;
        lc0 = load_cnt;
        load = mctx[f];
        pend = 1'b0;
        stalls = 0;
        if (!sop) msop_err = 1'b1;
        for (int i = 0; i < len; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_data     = 8'($urandom);
            bus.in_flow     = (i == 0) ? FLOW_W'(f) : FLOW_W'($urandom);
            bus.in_sop      = (i == 0) ? sop : 1'($urandom_range(0, 1));
            bus.in_eop      = (i == len - 1);
            bus.ctx_clr     = (i == clr_at);
            bus.ctx_clr_id  = FLOW_W'(clr_id);
            bus.match_ready = (i == pop_at);
            to = 1'b0;
            for (int t = 0; ; t++) begin
                @(negedge clk); rdy = bus.in_ready;
                @(posedge clk); #1;
                if (rdy) break;
                stalls++;
                if (t >= 8) begin to = 1'b1; break; end
            end
            if (to) begin
                chk("handshake_timeout", 0, 1);
                break;
            end
            if (i == pop_at && q.size() > 0) void'(q.pop_front());
            if (((load + i + 1) % STATE_MOD) == 3) begin
                if (q.size() < FIFO_DEPTH) q.push_back('{f, i});
                else movf = 1'b1;
            end
            if (i == clr_at) begin
                if (clr_id == f) pend = 1'b1;
                else mctx[clr_id] = 0;
            end
        end
        bus.in_valid = 1'b0; bus.in_eop = 1'b0;
        bus.ctx_clr = 1'b0; bus.match_ready = 1'b0;
        mctx[f] = pend ? 0 : (load + len) % STATE_MOD;
        chk("load_count", load_cnt - lc0, 1);
        chk("load_state", load_seen, load);
    endtask

    task automatic drain();
        rep_t r;
        bus.match_ready = 1'b1;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            chk("rep_valid", bus.match_valid, 1);
            chk("rep_flow", bus.match_flow, r.flow);
            chk("rep_offs", bus.match_offs, r.offs);
            @(posedge clk); #1;
        end
        bus.match_ready = 1'b0;
        @(negedge clk);
        chk("rep_empty", bus.match_valid, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit rst; int flow; int len; bit sop;
        int exp_load; int exp_nrep; int exp_offs; int exp_ctx; bit exp_sop_err; int exp_stall;
    } vec_t;
    vec_t vecs [7];

    initial begin
        int st;
        int acc;
        bit rdy;

        vecs[0] = '{1'b1, 2, 5, 1'b1, 0, 1, 2, 5, 1'b0, 2};
        vecs[1] = '{1'b1, 2, 2, 1'b1, 0, 0, 0, 2, 1'b0, 2};
        vecs[2] = '{1'b0, 5, 1, 1'b1, 0, 0, 0, 1, 1'b0, 2};
        vecs[3] = '{1'b0, 2, 1, 1'b1, 2, 1, 0, 3, 1'b0, 2};
        vecs[4] = '{1'b0, 9, 1, 1'b1, 0, 0, 0, 1, 1'b0, 2};
        vecs[5] = '{1'b0, 9, 1, 1'b0, 1, 0, 0, 2, 1'b1, 2};
        vecs[6] = '{1'b0, 9, 1, 1'b1, 2, 1, 0, 3, 1'b1, 2};

        do_reset();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_m_char_vld", bus.m_char_vld, 0);
        chk("rst_m_state_vld", bus.m_state_vld, 0);
        chk("rst_match_valid", bus.match_valid, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_sop_err", bus.sop_err, 0);
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst) do_reset();
            send_pkt(vecs[v].flow, vecs[v].len, vecs[v].sop, -1, 0, -1, st);
            chk("tbl_stall", st, vecs[v].exp_stall);
            chk("tbl_load", load_seen, vecs[v].exp_load);
            idle(1);
            chk("tbl_ctx", dut.ctx_q[vecs[v].flow], vecs[v].exp_ctx);
            @(negedge clk);
            chk("tbl_sop_err", bus.sop_err, vecs[v].exp_sop_err);
            chk("tbl_nrep", bus.match_valid, vecs[v].exp_nrep);
            if (vecs[v].exp_nrep != 0) begin
                chk("tbl_rep_flow", bus.match_flow, vecs[v].flow);
                chk("tbl_rep_offs", bus.match_offs, vecs[v].exp_offs);
            end
            @(posedge clk); #1;
            drain();
        end

        // Back-to-back packets: 3 non-streaming cycles between them
        do_reset();
        send_pkt(1, 2, 1'b1, -1, 0, -1, st);
        send_pkt(1, 1, 1'b1, -1, 0, -1, st);
        chk("b2b_stall", st, 3);
        chk("b2b_load", load_seen, 2);
        idle(1);
        drain();

        // Clear of the active flow mid-stream, then of an idle flow
        do_reset();
        send_pkt(3, 2, 1'b1, -1, 0, -1, st);
        idle(1);
        chk("clr_pre_ctx3", dut.ctx_q[3], 2);
        send_pkt(3, 4, 1'b1, 1, 3, -1, st);
        idle(1);
        chk("clr_act_ctx3", dut.ctx_q[3], 0);
        @(negedge clk);
        chk("clr_act_rep_offs", bus.match_offs, 0);
        @(posedge clk); #1;
        drain();
        send_pkt(7, 1, 1'b1, -1, 0, -1, st);
        idle(1);
        chk("clr_idle_pre_ctx7", dut.ctx_q[7], 1);
        bus.ctx_clr = 1'b1; bus.ctx_clr_id = 4'd7;
        @(posedge clk); #1;
        bus.ctx_clr = 1'b0;
        mctx[7] = 0;
        chk("clr_idle_ctx7", dut.ctx_q[7], 0);
        send_pkt(7, 1, 1'b1, -1, 0, -1, st);
        idle(1);

        // FIFO overflow and push+pop at full
        do_reset();
        for (int f = 0; f < 9; f++) begin
            send_pkt(f, 3, 1'b1, -1, 0, -1, st);
            if (f == 7) begin
                idle(1);
                chk("ovf_at_full", bus.overflow, 0);
            end
        end
        idle(1);
        chk("ovf_set", bus.overflow, movf);
        send_pkt(9, 3, 1'b1, -1, 0, 2, st);
        idle(1);
        chk("ovf_sticky", bus.overflow, 1);
        drain();

        // Reset in the middle of a packet
        do_reset();
        send_pkt(4, 3, 1'b1, -1, 0, -1, st);
        idle(1);
        @(negedge clk);
        chk("mid_pre_valid", bus.match_valid, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_flow = 4'd4; bus.in_sop = 1'b1; bus.in_eop = 1'b0;
        acc = 0;
        for (int t = 0; t < 10 && acc < 2; t++) begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
        end
        chk("mid_beats", acc, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_m_char_vld", bus.m_char_vld, 0);
        chk("mid_rst_match_valid", bus.match_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < NUM_FLOWS; f++) begin
            send_pkt(f, 1, 1'b1, -1, 0, -1, st);
            chk("post_rst_load", load_seen, 0);
        end
        idle(1);
        drain();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int f, len, clr_at, clr_id;
            bit sop;
            f      = $urandom_range(0, 3);
            len    = $urandom_range(1, 6);
            sop    = ($urandom_range(0, 9) != 0);
            clr_at = -1;
            clr_id = $urandom_range(0, 3);
            if (len > 1 && $urandom_range(0, 9) < 3) clr_at = $urandom_range(1, len - 1);
            send_pkt(f, len, sop, clr_at, clr_id, -1, st);
            idle(1);
            drain();
            if ($urandom_range(0, 4) == 0) begin
                clr_id = $urandom_range(0, 3);
                bus.ctx_clr = 1'b1; bus.ctx_clr_id = FLOW_W'(clr_id);
                @(posedge clk); #1;
                bus.ctx_clr = 1'b0;
                mctx[clr_id] = 0;
            end
        end
        @(negedge clk);
        chk("rnd_sop_err", bus.sop_err, msop_err);
        chk("rnd_overflow", bus.overflow, movf);
        for (int f = 0; f < 4; f++) chk("rnd_ctx", dut.ctx_q[f], mctx[f]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
